// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: turns a stream of desired next-Q bits into registered
// J/K excitation for an external JK flip-flop. Targets are buffered in a small
// FIFO, released one per cycle under step_en, and the flip-flop's Q is checked
// against the tracked model two edges after each step.
module jk_excitation_driver #(
    parameter int DEPTH   = 4,   // FIFO entries, power of two, >= 2
    parameter int DC_FILL = 0,   // value substituted for excitation don't-cares
    parameter int CNT_W   = 8    // width of step_cnt / err_cnt
) (
    input  logic             Clk,
    input  logic             RST_B,
    input  logic             clear,
    input  logic             tgt_bit,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic             step_en,
    output logic             J,
    output logic             K,
    output logic             drv_valid,
    input  logic             Q_obs,
    output logic             mismatch,
    output logic             q_model,
    output logic [CNT_W-1:0] step_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             empty,
    output logic             full
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic        DC       = (DC_FILL != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TAIL  = 2'd2
    } state_t;

    // FIFO storage and pointers; count carries the extra bit that separates
    // full from empty when the pointers are equal.
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic   push;
    logic   pop;
    logic   head;
    logic   j_nxt;
    logic   k_nxt;
    logic   exp_q;
    logic   chk_pend;
    logic   chk_fire;
    state_t state;
    state_t state_nxt;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign tgt_ready = !full;

    // A push in a clear cycle is dropped; pops never bypass an empty FIFO.
    assign push = tgt_valid && !full && !clear;
    assign pop  = step_en && !empty && !clear;
    assign head = mem[rd_ptr];

    // A check only fires while the controller still considers a step in flight.
    assign chk_fire = chk_pend && (state != IDLE);

    // Excitation table lookup for the step about to be issued.
    always_comb begin
        j_nxt = 1'b0;
        k_nxt = 1'b0;
        case ({q_model, head})
            2'b00: begin j_nxt = 1'b0; k_nxt = DC;   end
            2'b01: begin j_nxt = 1'b1; k_nxt = DC;   end
            2'b10: begin j_nxt = DC;   k_nxt = 1'b1; end
            2'b11: begin j_nxt = DC;   k_nxt = 1'b0; end
            default: begin j_nxt = 1'b0; k_nxt = 1'b0; end
        endcase
    end

    // FIFO data array; contents need no reset since occupancy gates reads.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= tgt_bit;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (!RST_B || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Step issue: register J/K, advance the Q model, count steps.
    always_ff @(posedge Clk) begin
        if (!RST_B) begin
            J         <= 1'b0;
            K         <= 1'b0;
            drv_valid <= 1'b0;
            q_model   <= 1'b0;
            step_cnt  <= '0;
        end else if (clear) begin
            J         <= 1'b0;
            K         <= 1'b0;
            drv_valid <= 1'b0;
            q_model   <= Q_obs;   // resync to a flip-flop that may lack reset
            step_cnt  <= '0;
        end else if (pop) begin
            J         <= j_nxt;
            K         <= k_nxt;
            drv_valid <= 1'b1;
            q_model   <= head;
            if (step_cnt != CNT_MAX) step_cnt <= step_cnt + 1'b1;
        end else begin
            J         <= 1'b0;
            K         <= 1'b0;
            drv_valid <= 1'b0;
        end
    end

    // Check pipeline: arm while J/K are presented, compare one edge later
    // once the external flip-flop has clocked them in.
    always_ff @(posedge Clk) begin
        if (!RST_B || clear) begin
            chk_pend <= 1'b0;
            exp_q    <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            chk_pend <= drv_valid;
            if (drv_valid) exp_q <= q_model;
            mismatch <= chk_fire && (Q_obs != exp_q);
            if (chk_fire && (Q_obs != exp_q) && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge Clk) begin
        if (!RST_B) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control next-state: DRIVE while popping, TAIL while checks drain.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (pop) state_nxt = DRIVE;
                DRIVE:   state_nxt = pop ? DRIVE : TAIL;
                TAIL: begin
                    if (pop)                         state_nxt = DRIVE;
                    else if (!drv_valid && !chk_pend) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Inverse of the JK flip-flop: takes a stream of desired next-state bits and produces the J/K excitation that drives an external JK flip-flop through that sequence.
- Buffers targets in a small FIFO, paces them with a step enable, and tracks a model of Q.
- Checks the flip-flop's observed Q against the expected value and counts steps and errors.
- Sits between a stimulus source or bench and a JK flip-flop under test (with or without reset).

Parameters:
- DEPTH, 4: target FIFO depth in entries; must be a power of two and at least 2.
- DC_FILL, 0: resolves the excitation-table don't-cares. 0 fills X with 0 (set/reset/hold style); 1 fills X with 1 (toggle style).
- CNT_W, 8: width of step_cnt and err_cnt.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- RST_B  input  1  synchronous reset, active-low.
- clear  input  1  synchronous flush and resync, active-high.
- tgt_bit  input  1  desired next Q value.
- tgt_valid  input  1  tgt_bit is valid this cycle.
- tgt_ready  output  1  FIFO can accept a target; equals !full.
- step_en  input  1  permits one FIFO pop per cycle.
- J  output  1  registered J excitation.
- K  output  1  registered K excitation.
- drv_valid  output  1  J/K carry a real step this cycle.
- Q_obs  input  1  Q from the external flip-flop.
- mismatch  output  1  one-cycle pulse when Q_obs differs from the expected value.
- q_model  output  1  tracked expected Q.
- step_cnt  output  CNT_W  number of steps issued, saturating.
- err_cnt  output  CNT_W  number of mismatches, saturating.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.

Behaviour:
- Reset (RST_B=0 at an edge) clears everything:
  - FIFO empty; full=0; tgt_ready=1.
  - J=0, K=0, drv_valid=0, q_model=0, mismatch=0, step_cnt=0, err_cnt=0.
  - Check pipeline cleared.
  - Reset has priority over clear.
- Push: a target is written when tgt_valid && tgt_ready at the edge.
  - tgt_ready is !full only; it does not look ahead at a same-cycle pop.
  - When the FIFO is full, a push is ignored even if a pop occurs in the same cycle.
- Pop: occurs when step_en && !empty at the edge. No bypass, so a bit pushed into an empty FIFO can pop at the next edge at the earliest.
  - On a pop at edge t, J/K are registered from (q_model, target) and q_model is updated to target.
  - drv_valid=1 for the cycle after t.
  - step_cnt increments, saturating at all-ones.
- Excitation table, written as q_model -> target : J,K with X = DC_FILL:
  - 0->0 : 0,X
  - 0->1 : 1,X
  - 1->0 : X,1
  - 1->1 : X,0
- With no pop at an edge: J=0, K=0 (hold), drv_valid=0, q_model unchanged.
- Simultaneous push and pop on a non-full FIFO: both occur and the occupancy is unchanged.
- Pointers wrap modulo DEPTH; occupancy uses a separate count (or an extra pointer bit) to distinguish full from empty.
- Check pipeline:
  - At edge t+1, where drv_valid=1 in the cycle before it, latch exp_q=q_model and set chk_pend.
  - At edge t+2, if chk_pend: mismatch<=(Q_obs!=exp_q), err_cnt increments on mismatch (saturating), and chk_pend clears unless it was re-armed.
  - Back-to-back steps keep one check in flight per cycle.
  - mismatch is 0 whenever no check is performed.
- Control FSM:
  - IDLE: FIFO empty and no check pending.
  - DRIVE: a pop occurred this cycle.
  - TAIL: checks are still pending after the FIFO drained.
  - Transitions: IDLE->DRIVE on a pop; DRIVE->TAIL when the FIFO is empty or step_en=0; TAIL->IDLE once no check is pending; TAIL->DRIVE on a pop.
- clear=1 at an edge:
  - Flushes the FIFO, zeroes step_cnt and err_cnt, cancels pending checks.
  - Forces J=K=0 and drv_valid=0.
  - Loads q_model<=Q_obs, which resyncs to a flip-flop that has no reset.
  - A push in the same cycle as clear is dropped.
- Reset or clear mid-operation discards in-flight steps with no mismatch pulse.

Test Plan:
1. Reset (RST_B=0 for 2 cycles), DC_FILL=0, Q_obs driven by an ideal JK flip-flop fed from J/K, step_en=1, push 1,1,0,0,1 -> J,K sequence (1,0),(0,0),(0,1),(0,0),(1,0); q_model ends at 1; step_cnt=5; err_cnt=0; mismatch never asserted.
2. Same stimulus with DC_FILL=1 -> J,K sequence (1,1),(1,0),(1,1),(0,1),(1,1); flip-flop Q follows 1,1,0,0,1; err_cnt=0.
3. Q_obs tied to 0, push 1 -> mismatch pulses exactly 2 edges after the pop (one cycle after drv_valid); err_cnt=1; then push 0 -> no further pulse; err_cnt stays 1.
4. DEPTH=4, step_en=0, tgt_valid=1 for 5 cycles with bits 1,0,1,1,0 -> 4 accepted, full=1 and tgt_ready=0 after the 4th, 5th dropped; then step_en=1 -> pops 1,0,1,1 in order; empty=1 after the 4th pop.
5. After 3 steps with Q_obs=1, assert clear -> FIFO empty, step_cnt=0, err_cnt=0, q_model=1, no mismatch from the cancelled in-flight check.
6. CNT_W=2, Q_obs stuck opposite to the targets, 5 steps -> step_cnt and err_cnt both saturate at 3; mismatch still pulses on every step.
